md_operand_stage: RTL and testbench

MD_OPERAND_STAGE -- requirements
Module: md_operand_stage

---
 rtl/md_pkg.sv | 5 +
 rtl/md_src_mux.sv | 17 +
 rtl/md_operand_stage.sv | 121 ++++++++++++
 tb/tb_md_operand_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the mult/div operand stage.
package md_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_WAIT, ST_DONE} md_state_t;
    localparam int CYC_W = 16;
endpackage

// File: rtl/md_src_mux.sv
// N:1 operand source mux; any select at or beyond NSRC falls back to source 0.
module md_src_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] src,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out
);
    always_comb begin
        out = src[WIDTH-1:0];
        for (int i = 1; i < NSRC; i++) begin
            if (sel == SELW'(i)) out = src[i*WIDTH +: WIDTH];
        end
    end
endmodule

// File: rtl/md_operand_stage.sv
// Operand capture/handshake stage in front of a multi-cycle mult/div unit.
// Optional feature macro MD_SIGNED_ABS_EN: signed operands are converted to magnitude + sign.
module md_operand_stage
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] src_a,
    input  logic [NSRC*WIDTH-1:0] src_b,
    input  logic [SELW-1:0]       sel_a,
    input  logic [SELW-1:0]       sel_b,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic                  md_ready,
    input  logic                  md_done,
    output logic [WIDTH-1:0]      op_a,
    output logic [WIDTH-1:0]      op_b,
    output logic                  op_valid,
    output logic                  neg_a,
    output logic                  neg_b,
    output logic                  busy,
    output logic                  done,
    output logic [CYC_W-1:0]      cycles
);
    md_state_t        state;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;

    md_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_mux_a (
        .src (src_a),
        .sel (sel_a),
        .out (mux_a)
    );

    md_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_mux_b (
        .src (src_b),
        .sel (sel_b),
        .out (mux_b)
    );

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] c);
        return (&c) ? c : c + CYC_W'(1);
    endfunction

`ifdef MD_SIGNED_ABS_EN
    // The most-negative value negates to itself, which is the intended magnitude encoding.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cycles   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
`ifdef MD_SIGNED_ABS_EN
                        if (signed_op) begin
                            op_a  <= abs_mag(mux_a);
                            op_b  <= abs_mag(mux_b);
                            neg_a <= mux_a[WIDTH-1];
                            neg_b <= mux_b[WIDTH-1];
                        end else begin
                            op_a  <= mux_a;
                            op_b  <= mux_b;
                            neg_a <= 1'b0;
                            neg_b <= 1'b0;
                        end
`else
                        op_a  <= mux_a;
                        op_b  <= mux_b;
                        neg_a <= 1'b0;
                        neg_b <= 1'b0;
`endif
                        cycles   <= '0;
                        op_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (md_ready) begin
                        op_valid <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The cycle on which md_done is seen is counted too.
                    cycles <= sat_inc(cycles);
                    if (md_done) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_operand_stage.sv
// Self-checking bench for md_operand_stage: directed steps then random traffic against a phase-level model.
module tb_md_operand_stage;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] src_a = '0, src_b = '0;
    logic [95:0]  src3_a = '0, src3_b = '0;
    logic [1:0]   sel_a = '0, sel_b = '0;
    logic         start = 1'b0, signed_op = 1'b0, md_ready = 1'b0, md_done = 1'b0;

    logic [31:0] op_a, op_b, op3_a, op3_b;
    logic        op_valid, neg_a, neg_b, busy, done;
    logic        op3_valid, neg3_a, neg3_b, busy3, done3;
    logic [15:0] cycles, cycles3;

    int total = 0;
    int bad   = 0;

    // Model: phase 0=idle 1=offering 2=waiting 3=completing
    int          m_ph = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_na = 1'b0, m_nb = 1'b0;
    int          m_cyc = 0;

    always #5 clk = ~clk;

    md_operand_stage #(.WIDTH(32), .NSRC(4)) u_dut (
        .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b),
        .sel_a(sel_a), .sel_b(sel_b), .start(start), .signed_op(signed_op),
        .md_ready(md_ready), .md_done(md_done), .op_a(op_a), .op_b(op_b),
        .op_valid(op_valid), .neg_a(neg_a), .neg_b(neg_b), .busy(busy),
        .done(done), .cycles(cycles)
    );

    md_operand_stage #(.WIDTH(32), .NSRC(3)) u_dut3 (
        .clk(clk), .reset(reset), .src_a(src3_a), .src_b(src3_b),
        .sel_a(sel_a), .sel_b(sel_b), .start(start), .signed_op(signed_op),
        .md_ready(md_ready), .md_done(md_done), .op_a(op3_a), .op_b(op3_b),
        .op_valid(op3_valid), .neg_a(neg3_a), .neg_b(neg3_b), .busy(busy3),
        .done(done3), .cycles(cycles3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("op_a", op_a, m_a);
        chk("op_b", op_b, m_b);
        chk("neg_a", 32'(neg_a), 32'(m_na));
        chk("neg_b", 32'(neg_b), 32'(m_nb));
        chk("op_valid", 32'(op_valid), 32'(m_ph == 1));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("done", 32'(done), 32'(m_ph == 3));
        chk("cycles", 32'(cycles), m_cyc);
    endtask

    function automatic logic [31:0] pick(input logic [127:0] s, input int unsigned sel);
        int unsigned idx;
        idx = (sel >= 4) ? 0 : sel;
        return s[idx*32 +: 32];
    endfunction

    task automatic capture_one(input logic [31:0] v, input bit sg,
                               output logic [31:0] o, output logic n);
        o = v;
        n = 1'b0;
`ifdef MD_SIGNED_ABS_EN
        if (sg && v[31]) begin
            o = 32'd0 - v;
            n = 1'b1;
        end
`endif
    endtask

    task automatic model_reset();
        m_ph = 0; m_a = '0; m_b = '0; m_na = 1'b0; m_nb = 1'b0; m_cyc = 0;
    endtask

    task automatic step(input bit st, input int unsigned sa, input int unsigned sb,
                        input bit sg, input bit rdy, input bit mdd);
        @(negedge clk);
        start = st; sel_a = 2'(sa); sel_b = 2'(sb); signed_op = sg;
        md_ready = rdy; md_done = mdd;
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            case (m_ph)
                0: if (st) begin
                    capture_one(pick(src_a, sa), sg, m_a, m_na);
                    capture_one(pick(src_b, sb), sg, m_b, m_nb);
                    m_cyc = 0;
                    m_ph = 1;
                end
                1: if (rdy) m_ph = 2;
                2: begin
                    m_cyc = (m_cyc >= 65535) ? 65535 : m_cyc + 1;
                    if (mdd) m_ph = 3;
                end
                default: m_ph = 0;
            endcase
        end
        #1;
        check_all();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Basic capture with sources 2 and 1
        src_a = {$urandom, 32'h0000_0007, $urandom, $urandom};
        src_b = {$urandom, $urandom, 32'h0000_0003, $urandom};
        step(1, 2, 1, 0, 0, 0);
        chk("req35_a", op_a, 32'd7);
        chk("req35_b", op_b, 32'd3);
        chk("req35_valid", 32'(op_valid), 32'd1);

        // Stall in offer: new sources, start and md_done are all ignored
        for (int i = 0; i < 5; i++) begin
            src_a = {$urandom, $urandom, $urandom, $urandom};
            src_b = {$urandom, $urandom, $urandom, $urandom};
            step(1, 3, 0, 1, 0, 1);
        end
        step(0, 0, 0, 0, 1, 0);
        chk("wait_valid", 32'(op_valid), 32'd0);

        // Ten cycles in wait, start pulsed along the way
        for (int i = 0; i < 9; i++) step(i % 2, 0, 3, 0, 1, 0);
        step(1, 1, 1, 0, 0, 1);
        chk("req37_cycles", 32'(cycles), 32'd10);
        chk("req37_done", 32'(done), 32'd1);
        step(1, 0, 2, 1, 1, 1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("retain_a", op_a, 32'd7);
        chk("retain_cycles", 32'(cycles), 32'd10);
        step(0, 0, 0, 0, 0, 0);

        // Signed capture of -7 and the most-negative value
        src_a = {$urandom, $urandom, $urandom, 32'hFFFF_FFF9};
        src_b = {32'h8000_0000, $urandom, $urandom, $urandom};
        step(1, 0, 3, 1, 0, 0);
`ifdef MD_SIGNED_ABS_EN
        chk("req39_a", op_a, 32'd7);
        chk("req39_na", 32'(neg_a), 32'd1);
`else
        chk("raw_a", op_a, 32'hFFFF_FFF9);
        chk("raw_na", 32'(neg_a), 32'd0);
`endif
        chk("req39_b", op_b, 32'h8000_0000);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of wait
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        step(0, 0, 0, 0, 0, 1);
        chk("no_done_after_reset", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        src_a = {$urandom, $urandom, $urandom, $urandom};
        src_b = {$urandom, $urandom, $urandom, $urandom};
        src3_a = {$urandom, $urandom, 32'h1234_5678};
        src3_b = {32'hCAFE_0002, $urandom, 32'h0BAD_0000};

        // Out-of-range select on the 3-source instance falls back to source 0
        step(1, 3, 2, 0, 0, 0);
        chk("nsrc3_a", op3_a, 32'h1234_5678);
        chk("nsrc3_b", op3_b, 32'hCAFE_0002);
        chk("nsrc3_valid", 32'(op3_valid), 32'd1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (m_ph == 0) begin
                src_a = {$urandom, $urandom, $urandom, $urandom};
                src_b = {$urandom, $urandom, $urandom, $urandom};
            end
            step(($urandom % 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), ($urandom % 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
